// File: rtl/tdc_therm_accum.sv
// tdc_therm_accum: synchronises a vernier-TDC thermometer code, captures it a fixed delay after each shot edge and accumulates N codes.
// Optional macro TDC_HIST_EN adds nine 8-bit saturating histogram bins.
`default_nettype none

module tdc_therm_accum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] therm_in,
  input  logic       shot,
  input  logic       arm,
  input  logic [1:0] n_sel,
  input  logic       rd_ack,
  output logic       busy,
  output logic       res_valid,
  output logic [9:0] sum,
  output logic [3:0] last_code,
  output logic [6:0] bubble_cnt,
  input  logic [3:0] hist_sel,
  output logic [7:0] hist_out
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_SHOT = 3'd1;
  localparam logic [2:0] SETTLE    = 3'd2;
  localparam logic [2:0] CAPTURE   = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [7:0] therm_s1, therm_s2;
  logic       shot_s1, shot_s2;
  logic       shot_edge;
  logic [2:0] state;
  logic [1:0] settle_cnt;
  logic [6:0] samp_cnt;
  logic [6:0] samp_next;
  logic [6:0] n_target;
  logic [1:0] n_lat;
  logic [3:0] code;
  logic       is_therm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      therm_s1 <= '0;
      therm_s2 <= '0;
      shot_s1  <= 1'b0;
      shot_s2  <= 1'b0;
    end else begin
      therm_s1 <= therm_in;
      therm_s2 <= therm_s1;
      shot_s1  <= shot;
      shot_s2  <= shot_s1;
    end
  end

  assign shot_edge = shot_s1 & ~shot_s2;

  always_comb begin
    code = '0;
    for (int i = 0; i < 8; i++) begin
      code = code + {3'b000, therm_s2[i]};
    end
  end

  // A valid thermometer word is 2^k-1, i.e. it shares no set bit with itself plus one.
  assign is_therm  = ((therm_s2 & (therm_s2 + 8'd1)) == 8'd0);
  assign n_target  = 7'd1 << {n_lat, 1'b0};
  assign samp_next = samp_cnt + 7'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      n_lat      <= '0;
      sum        <= '0;
      last_code  <= '0;
      bubble_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            sum        <= '0;
            bubble_cnt <= '0;
            samp_cnt   <= '0;
            n_lat      <= n_sel;
            state      <= WAIT_SHOT;
          end
        end
        WAIT_SHOT: begin
          if (shot_edge) begin
            settle_cnt <= 2'd3;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // Leaving as the counter reaches zero puts CAPTURE four cycles after the edge pulse.
          settle_cnt <= settle_cnt - 2'd1;
          if (settle_cnt == 2'd1) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          sum       <= sum + {6'd0, code};
          last_code <= code;
          samp_cnt  <= samp_next;
          if (!is_therm) begin
            bubble_cnt <= bubble_cnt + 7'd1;
          end
          state <= (samp_next == n_target) ? DONE : WAIT_SHOT;
        end
        DONE: begin
          if (rd_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == WAIT_SHOT) || (state == SETTLE) || (state == CAPTURE);
  assign res_valid = (state == DONE);

`ifdef TDC_HIST_EN
  logic [7:0] bins [9];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 9; b++) begin
        bins[b] <= '0;
      end
    end else if (state == IDLE && arm) begin
      for (int b = 0; b < 9; b++) begin
        bins[b] <= '0;
      end
    end else if (state == CAPTURE) begin
      for (int b = 0; b < 9; b++) begin
        if (code == 4'(b) && bins[b] != 8'hFF) begin
          bins[b] <= bins[b] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    hist_out = '0;
    if (hist_sel <= 4'd8) begin
      hist_out = bins[hist_sel];
    end
  end
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^hist_sel;
  assign hist_out        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdc_therm_accum.sv
// tb_tdc_therm_accum: directed plus randomised runs checked against an arithmetic reference model.
`default_nettype none

module tb_tdc_therm_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] therm_in;
  logic       shot;
  logic       arm;
  logic [1:0] n_sel;
  logic       rd_ack;
  logic       busy;
  logic       res_valid;
  logic [9:0] sum;
  logic [3:0] last_code;
  logic [6:0] bubble_cnt;
  logic [3:0] hist_sel;
  logic [7:0] hist_out;

  tdc_therm_accum dut (
    .clk(clk), .rst_n(rst_n), .therm_in(therm_in), .shot(shot), .arm(arm),
    .n_sel(n_sel), .rd_ack(rd_ack), .busy(busy), .res_valid(res_valid),
    .sum(sum), .last_code(last_code), .bubble_cnt(bubble_cnt),
    .hist_sel(hist_sel), .hist_out(hist_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_sum, m_bub, m_last;
  int m_hist [9];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int popcnt(input logic [7:0] t);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(t[i]);
    return c;
  endfunction

  function automatic bit thermometer(input logic [7:0] t);
    for (int k = 0; k <= 8; k++) begin
      if (int'(t) == (1 << k) - 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_sum = 0;
    m_bub = 0;
    for (int b = 0; b < 9; b++) m_hist[b] = 0;
  endtask

  task automatic model_sample(input logic [7:0] t);
    int c = popcnt(t);
    m_sum += c;
    m_last = c;
    if (!thermometer(t)) m_bub++;
    if (m_hist[c] < 255) m_hist[c]++;
  endtask

  task automatic arm_run(input int ns);
    @(negedge clk);
    n_sel = 2'(ns);
    arm   = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    model_clear();
  endtask

  task automatic sample(input logic [7:0] t);
    @(negedge clk);
    therm_in = t;
    repeat (3) @(negedge clk);
    shot = 1'b1;
    repeat (8) @(negedge clk);
    shot = 1'b0;
    repeat (3) @(negedge clk);
    model_sample(t);
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sum"}, sum, m_sum);
    check({tag, "_last"}, last_code, m_last);
    check({tag, "_bubble"}, bubble_cnt, m_bub);
    for (int s = 0; s < 10; s++) begin
      hist_sel = 4'(s);
      #1;
`ifdef TDC_HIST_EN
      check({tag, "_hist"}, hist_out, (s < 9) ? m_hist[s] : 0);
`else
      check({tag, "_hist"}, hist_out, 0);
`endif
    end
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check({tag, "_ack_valid"}, res_valid, 0);
    check({tag, "_ack_busy"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; therm_in = '0; shot = 1'b0; arm = 1'b0;
    n_sel = '0; rd_ack = 1'b0; hist_sel = '0;
    m_last = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_last", last_code, 0);
    check("rst_bubble", bubble_cnt, 0);
    rst_n = 1'b1;

    // Single sample with exact capture latency: 2 sync edges to the pulse, then 4 cycles.
    arm_run(0);
    check("arm_busy", busy, 1);
    therm_in = 8'h0F;
    repeat (3) @(negedge clk);
    shot = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("lat_early", res_valid, 0);
    @(posedge clk);
    #1 check("lat_exact", res_valid, 1);
    @(negedge clk);
    shot = 1'b0;
    model_sample(8'h0F);
    repeat (3) @(negedge clk);
    finish_run("r32");
    ack("r32");

    arm_run(1);
    sample(8'h01); sample(8'h03); sample(8'hFF); sample(8'h00);
    finish_run("r33");
    ack("r33");

    arm_run(0);
    sample(8'h05);
    finish_run("r34");
    ack("r34");

    arm_run(3);
    for (int i = 0; i < 64; i++) sample(8'hFF);
    finish_run("r35");
    ack("r35");

    // Reset partway through a run, then arm in the very first cycle after release.
    arm_run(1);
    sample(8'h07); sample(8'h3F);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("r36_busy", busy, 0);
    check("r36_valid", res_valid, 0);
    check("r36_sum", sum, 0);
    check("r36_last", last_code, 0);
    check("r36_bubble", bubble_cnt, 0);
    rst_n = 1'b1;
    n_sel = 2'd1;
    arm   = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    model_clear();
    m_last = 0;
    check("r36_rearm_busy", busy, 1);
    sample(8'h01); sample(8'h09); sample(8'h1F); sample(8'h7F);
    finish_run("r36");
    ack("r36");

    // Stray arm, n_sel change, rd_ack while busy and a second shot inside SETTLE.
    arm_run(1);
    sample(8'h03);
    @(negedge clk);
    n_sel  = 2'd3;
    arm    = 1'b1;
    rd_ack = 1'b1;
    @(negedge clk);
    arm    = 1'b0;
    rd_ack = 1'b0;
    check("r37_busy", busy, 1);
    therm_in = 8'h0F;
    repeat (3) @(negedge clk);
    shot = 1'b1;
    @(negedge clk);
    shot = 1'b0;
    @(negedge clk);
    shot = 1'b1;
    repeat (8) @(negedge clk);
    shot = 1'b0;
    repeat (3) @(negedge clk);
    model_sample(8'h0F);
    check("r37_busy_mid", busy, 1);
    sample(8'h11);
    check("r37_busy_late", busy, 1);
    sample(8'hFF);
    finish_run("r37");

    // arm and rd_ack together in DONE: rd_ack wins.
    @(negedge clk);
    arm    = 1'b1;
    rd_ack = 1'b1;
    @(negedge clk);
    arm    = 1'b0;
    rd_ack = 1'b0;
    check("r27_valid", res_valid, 0);
    @(negedge clk);
    check("r27_busy", busy, 0);

    for (int r = 0; r < 6; r++) begin
      int ns = int'($urandom_range(0, 2));
      arm_run(ns);
      for (int i = 0; i < (1 << (2 * ns)); i++) begin
        logic [7:0] t;
        if ($urandom_range(0, 1) == 0) t = 8'((1 << $urandom_range(0, 8)) - 1);
        else t = 8'($urandom);
        sample(t);
      end
      finish_run("rand");
      ack("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
